// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN (appends an even-parity bit to each frame).
package word_serializer_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    localparam int SER_DEFAULT_WIDTH = 8;

    // Number of serial bits emitted per accepted word.
    function automatic int ser_frame_len(input int width);
`ifdef WORD_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel-in handshake plus serial-out stream of the word serializer.
// master = the serializer itself, slave = the environment feeding it and consuming the stream.
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;
    logic             busy;

    modport master (
        input  in_data, in_valid,
        output in_ready, out_bit, out_valid, out_last, busy
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, out_bit, out_valid, out_last, busy
    );
endinterface

// File: rtl/word_serializer_hold_buf.sv
// One-entry holding register: write sets full, read clears it.
// Writes and reads never coincide because the top only writes while empty and only reads while full.
module ser_hold_buf
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full
);
    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while r_full is set.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_data <= i_wr_data;
        end
    end

    assign o_rd_data = r_data;
    assign o_full    = r_full;
endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter, MSB first, with a one-word hold register for gapless back-to-back frames.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN (even-parity bit after the LSB, FRAME_LEN = WIDTH+1).
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    word_serializer_if.master   bus
);
    localparam int FRAME_LEN = ser_frame_len(WIDTH);
    localparam int CNT_W     = $clog2(WIDTH + 1);

    ser_state_t       r_state;
    ser_state_t       w_state_next;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_out_bit;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_busy;

    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic             w_hold_wr;
    logic             w_hold_rd;
    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_bit_next;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_hold_wr),
        .i_wr_data (bus.in_data),
        .i_rd      (w_hold_rd),
        .o_rd_data (w_hold_data),
        .o_full    (w_hold_full)
    );

    assign bus.in_ready = !w_hold_full && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_last       = (r_cnt == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        w_state_next = r_state;
        w_sreg_next  = r_sreg;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_load_data  = bus.in_data;
        w_hold_wr    = 1'b0;
        w_hold_rd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_sreg_next = r_sreg << 1;
                    w_cnt_next  = r_cnt + CNT_W'(1);
                    w_hold_wr   = w_accept;
                end else if (w_hold_full) begin
                    w_load      = 1'b1;
                    w_load_data = w_hold_data;
                    w_hold_rd   = 1'b1;
                end else if (w_accept) begin
                    // Word offered on the last bit goes straight into the shifter.
                    w_load = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
        endcase
        if (w_load) begin
            w_sreg_next = w_load_data;
            w_cnt_next  = '0;
        end
    end

`ifdef WORD_SERIALIZER_PARITY_EN
    logic r_parity;
    logic w_parity_next;

    assign w_parity_next = w_load ? ^w_load_data : r_parity;
    // Once all data bits have been shifted out, the parity bit takes the output slot.
    assign w_bit_next    = (w_cnt_next == CNT_W'(WIDTH)) ? w_parity_next : w_sreg_next[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`else
    assign w_bit_next = w_sreg_next[WIDTH-1];
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sreg      <= w_sreg_next;
            r_cnt       <= w_cnt_next;
            r_out_bit   <= (w_state_next == SHIFT) ? w_bit_next : 1'b0;
            r_out_valid <= (w_state_next == SHIFT);
            r_out_last  <= (w_state_next == SHIFT) && (w_cnt_next == CNT_W'(FRAME_LEN - 1));
            r_busy      <= (w_state_next == SHIFT) || w_hold_wr || (w_hold_full && !w_hold_rd);
        end
    end

    assign bus.out_bit   = r_out_bit;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer; also covers WORD_SERIALIZER_PARITY_EN builds.
module tb_word_serializer;
    localparam int W = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic q_bit[$];
    logic q_last[$];
    int   q_cyc[$];
    logic ready_log[0:4095];

    word_serializer_if #(.WIDTH(W)) bus ();

    word_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            q_bit.push_back(bus.out_bit);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
        end
        if (cyc < 4096) ready_log[cyc] = bus.in_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_bit.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.out_valid) done = 1'b1;
        end
        if (!done) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] frame_bits(input logic [7:0] w);
`ifdef WORD_SERIALIZER_PARITY_EN
        return {55'd0, w, ^w};
`else
        return {56'd0, w};
`endif
    endfunction

    // Compares the captured stream with the concatenated frames of nw words (first word in the top byte).
    task automatic check_stream(input string tag, input logic [31:0] words, input int nw, input int start_cyc);
        logic [63:0] exp_b;
        logic [63:0] exp_l;
        logic [63:0] got_b;
        logic [63:0] got_l;
        logic [7:0]  w;
        int          n;
        exp_b = '0; exp_l = '0; got_b = '0; got_l = '0;
        n = nw * FL;
        for (int i = 0; i < nw; i++) begin
            w = words[8*(nw-1-i) +: 8];
            exp_b = (exp_b << FL) | frame_bits(w);
            exp_l = (exp_l << FL) | 64'd1;
        end
        for (int i = 0; i < q_bit.size(); i++) begin
            got_b = {got_b[62:0], q_bit[i]};
            got_l = {got_l[62:0], q_last[i]};
        end
        check_eq({tag, "_count"}, 64'(q_bit.size()), 64'(n));
        check_eq({tag, "_bits"}, got_b, exp_b);
        check_eq({tag, "_last"}, got_l, exp_l);
        if (q_cyc.size() > 0) begin
            check_eq({tag, "_latency"}, 64'(q_cyc[0]), 64'(start_cyc));
            check_eq({tag, "_span"}, 64'(q_cyc[q_cyc.size()-1] - q_cyc[0]), 64'(n - 1));
        end else begin
            check_eq({tag, "_empty"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        int start;
        int cnt;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;

        // Reset state
        tick();
        tick();
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_bit", 64'(bus.out_bit), 64'd0);
        check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single word, accepted on the first edge with rst low
        clear_q();
        bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        tick();
        start = cyc;
        bus.in_valid = 1'b0;
        wait_idle("single");
        check_stream("single_a5", 32'h000000A5, 1, start);
        check_eq("single_end_valid", 64'(bus.out_valid), 64'd0);
        check_eq("single_end_busy", 64'(bus.busy), 64'd0);

        // Back-to-back through the hold register
        tick();
        clear_q();
        bus.in_data = 8'h05; bus.in_valid = 1'b1;
        tick();
        start = cyc;
        bus.in_data = 8'hA0;
        tick();
        bus.in_valid = 1'b0;
        wait_idle("b2b");
        check_stream("b2b", 32'h000005A0, 2, start);
        cnt = 0;
        for (int c = start + 1; c <= start + FL - 1; c++) if (!ready_log[c]) cnt++;
        check_eq("b2b_ready_low_cycles", 64'(cnt), 64'(FL - 1));
        check_eq("b2b_ready_c1", 64'(ready_log[start]), 64'd1);
        check_eq("b2b_ready_rise", 64'(ready_log[start + FL]), 64'd1);

        // Backpressure: in_valid held high across four words
        tick();
        clear_q();
        start = -1;
        bus.in_valid = 1'b1;
        for (int wv = 1; wv <= 4; wv++) begin
            bus.in_data = 8'(wv);
            for (int k = 0; k < 40 && !bus.in_ready; k++) tick();
            tick();
            if (wv == 1) start = cyc;
        end
        bus.in_valid = 1'b0;
        wait_idle("bp");
        check_stream("bp", 32'h01020304, 4, start);
        cnt = 0;
        for (int c = start; c < start + 3 * FL; c++) if (ready_log[c]) cnt++;
        check_eq("bp_ready_high_cycles", 64'(cnt), 64'd3);

        // Reset on the 4th bit of 8'hFF
        tick();
        clear_q();
        bus.in_data = 8'hFF; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_out_last", 64'(bus.out_last), 64'd0);
        check_eq("midrst_bits_before", 64'(q_bit.size()), 64'd4);
        rst = 1'b0;
        clear_q();
        bus.in_data = 8'h5A; bus.in_valid = 1'b1;
        tick();
        start = cyc;
        bus.in_valid = 1'b0;
        wait_idle("midrst");
        check_stream("midrst_5a", 32'h0000005A, 1, start);

        // Accept exactly on the last-bit cycle with the hold register empty
        tick();
        clear_q();
        bus.in_data = 8'h3C; bus.in_valid = 1'b1;
        tick();
        start = cyc;
        bus.in_valid = 1'b0;
        repeat (FL - 1) tick();
        check_eq("lastacc_last_flag", 64'(bus.out_last), 64'd1);
        check_eq("lastacc_ready", 64'(bus.in_ready), 64'd1);
        bus.in_data = 8'h81; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_idle("lastacc");
        check_stream("lastacc", 32'h00003C81, 2, start);

`ifdef WORD_SERIALIZER_PARITY_EN
        // Parity bit values, hand-computed
        tick();
        clear_q();
        bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        tick();
        start = cyc;
        bus.in_valid = 1'b0;
        wait_idle("par_a5");
        check_stream("par_a5", 32'h000000A5, 1, start);
        if (q_bit.size() >= 9) check_eq("par_a5_bit9", 64'(q_bit[8]), 64'd0);
        else check_eq("par_a5_len", 64'(q_bit.size()), 64'd9);
        tick();
        clear_q();
        bus.in_data = 8'h07; bus.in_valid = 1'b1;
        tick();
        start = cyc;
        bus.in_valid = 1'b0;
        wait_idle("par_07");
        check_stream("par_07", 32'h00000007, 1, start);
        if (q_bit.size() >= 9) check_eq("par_07_bit9", 64'(q_bit[8]), 64'd1);
        else check_eq("par_07_len", 64'(q_bit.size()), 64'd9);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
